// File: rtl/sort_if.sv
// Host-side port bundle of sort_engine: load/readback port, start/order control and status.
// Handshake: start and wr are single-cycle strobes that take effect only at an edge where ready=1.
interface sort_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) ();
  logic             start;
  logic             desc;
  logic             wr;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             ready;
  logic [AW-1:0]    swap_cnt;

  modport master (
    output start, desc, wr, addr, datain,
    input  dataout, ready, swap_cnt
  );

  modport slave (
    input  start, desc, wr, addr, datain,
    output dataout, ready, swap_cnt
  );
endinterface

// File: rtl/sort_engine.sv
// In-place selection sorter over a DEPTH x WIDTH register array with runtime order,
// optional signed compare and a per-sort swap counter.
module sort_engine #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    sort_if.slave      bus,
    output logic [1:0] dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_I  = AW'(DEPTH - 2);
    localparam logic [AW-1:0] LAST_J  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OUTER = 2'd1,
        INNER = 2'd2,
        SWAP  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] best;
    logic [WIDTH-1:0] cand;
    logic [AW-1:0]    i, j, bi;
    logic [AW-1:0]    bi_final;
    logic [AW-1:0]    swap_cnt;
    logic [WIDTH-1:0] dataout;
    logic             ready;
    logic             desc_q;
    logic             addr_ok;
    logic             lt, gt, take;
    logic             last_j, last_i;

    assign addr_ok   = {1'b0, bus.addr} < DEPTH_W;
    assign last_j    = (j == LAST_J);
    assign last_i    = (i == LAST_I);
    assign cand      = mem[j];

    assign bus.dataout  = dataout;
    assign bus.ready    = ready;
    assign bus.swap_cnt = swap_cnt;
    assign dbg_state    = state;

    // Strict compare against the running best keeps the lowest index among equal keys.
    always_comb begin
        lt = 1'b0;
        gt = 1'b0;
        if (SIGNED) begin
            lt = $signed(cand) < $signed(best);
            gt = $signed(cand) > $signed(best);
        end else begin
            lt = cand < best;
            gt = cand > best;
        end
        take     = desc_q ? gt : lt;
        bi_final = take ? j : bi;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = OUTER;
                end
            end
            OUTER: begin
                state_n = INNER;
            end
            INNER: begin
                if (last_j) begin
                    if (bi_final != i) begin
                        state_n = SWAP;
                    end else if (last_i) begin
                        state_n = IDLE;
                    end else begin
                        state_n = OUTER;
                    end
                end
            end
            SWAP: begin
                state_n = last_i ? IDLE : OUTER;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            state    <= IDLE;
            dataout  <= '0;
            ready    <= 1'b1;
            swap_cnt <= '0;
            desc_q   <= 1'b0;
            best     <= '0;
            i        <= '0;
            j        <= '0;
            bi       <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        desc_q   <= bus.desc;
                        i        <= '0;
                        swap_cnt <= '0;
                        ready    <= 1'b0;
                    end else if (bus.wr) begin
                        if (addr_ok) begin
                            mem[bus.addr] <= bus.datain;
                        end
                    end else begin
                        dataout <= addr_ok ? mem[bus.addr] : '0;
                    end
                end
                OUTER: begin
                    best <= mem[i];
                    bi   <= i;
                    j    <= i + AW'(1);
                end
                INNER: begin
                    if (take) begin
                        best <= cand;
                    end
                    bi <= bi_final;
                    if (!last_j) begin
                        j <= j + AW'(1);
                    end else if (bi_final == i) begin
                        // No swap needed: the NEXT decision happens in this cycle.
                        if (last_i) begin
                            ready <= 1'b1;
                        end else begin
                            i <= i + AW'(1);
                        end
                    end
                end
                SWAP: begin
                    mem[i]   <= mem[bi];
                    mem[bi]  <= mem[i];
                    swap_cnt <= swap_cnt + AW'(1);
                    if (last_i) begin
                        ready <= 1'b1;
                    end else begin
                        i <= i + AW'(1);
                    end
                end
                default: begin
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: three instances (8x8 unsigned, 8x8 signed, 5x12 unsigned) driven
// through shared stimulus and checked against a behavioural selection-sort model.
module tb_sort_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  logic        start_v = 1'b0;
  logic        desc_v  = 1'b0;
  logic        wr_v    = 1'b0;
  logic [2:0]  addr_v  = '0;
  logic [11:0] din_v   = '0;

  logic [11:0] dout_m;
  logic        ready_m;
  logic [2:0]  swap_m;
  logic [1:0]  dbg_u, dbg_s, dbg_p;

  sort_if #(.WIDTH(8),  .DEPTH(8)) if_u ();
  sort_if #(.WIDTH(8),  .DEPTH(8)) if_s ();
  sort_if #(.WIDTH(12), .DEPTH(5)) if_p ();

  sort_engine #(.WIDTH(8),  .DEPTH(8), .SIGNED(1'b0)) u_uns (.clk(clk), .rst(rst), .bus(if_u), .dbg_state(dbg_u));
  sort_engine #(.WIDTH(8),  .DEPTH(8), .SIGNED(1'b1)) u_sgn (.clk(clk), .rst(rst), .bus(if_s), .dbg_state(dbg_s));
  sort_engine #(.WIDTH(12), .DEPTH(5), .SIGNED(1'b0)) u_par (.clk(clk), .rst(rst), .bus(if_p), .dbg_state(dbg_p));

  assign if_u.start = start_v && (sel == 0);
  assign if_s.start = start_v && (sel == 1);
  assign if_p.start = start_v && (sel == 2);
  assign if_u.wr    = wr_v && (sel == 0);
  assign if_s.wr    = wr_v && (sel == 1);
  assign if_p.wr    = wr_v && (sel == 2);
  assign if_u.desc  = desc_v;
  assign if_s.desc  = desc_v;
  assign if_p.desc  = desc_v;
  assign if_u.addr  = addr_v;
  assign if_s.addr  = addr_v;
  assign if_p.addr  = addr_v;
  assign if_u.datain = din_v[7:0];
  assign if_s.datain = din_v[7:0];
  assign if_p.datain = din_v;

  always_comb begin
    dout_m  = {4'b0, if_u.dataout};
    ready_m = if_u.ready;
    swap_m  = if_u.swap_cnt;
    case (sel)
      1: begin
        dout_m  = {4'b0, if_s.dataout};
        ready_m = if_s.ready;
        swap_m  = if_s.swap_cnt;
      end
      2: begin
        dout_m  = if_p.dataout;
        ready_m = if_p.ready;
        swap_m  = if_p.swap_cnt;
      end
      default: ;
    endcase
  end

  int cfg_w[3] = '{8, 8, 12};
  int cfg_d[3] = '{8, 8, 5};
  int cfg_s[3] = '{0, 1, 0};

  int shadow[3][8];
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_shadow();
    for (int a = 0; a < 3; a++)
      for (int k = 0; k < 8; k++) shadow[a][k] = 0;
  endtask

  task automatic write_mem(input int a, input int d);
    wr_v = 1'b1;
    addr_v = 3'(a);
    din_v = 12'(d);
    tick();
    wr_v = 1'b0;
    if (a < cfg_d[sel]) shadow[sel][a] = d & ((1 << cfg_w[sel]) - 1);
  endtask

  task automatic read_mem(input int a, output logic [11:0] v);
    wr_v = 1'b0;
    addr_v = 3'(a);
    tick();
    v = dout_m;
  endtask

  // Reference: textbook selection sort on integer keys, swapping only when the
  // first extreme element is not already in place.
  task automatic model_sort(input bit d, output int sw);
    int n, w;
    int key[8];
    int raw[8];
    int best, t;
    n = cfg_d[sel];
    w = cfg_w[sel];
    sw = 0;
    for (int k = 0; k < n; k++) begin
      raw[k] = shadow[sel][k];
      key[k] = (cfg_s[sel] != 0 && raw[k] >= (1 << (w - 1))) ? raw[k] - (1 << w) : raw[k];
    end
    for (int a = 0; a < n - 1; a++) begin
      best = a;
      for (int b = a + 1; b < n; b++)
        if (d ? (key[b] > key[best]) : (key[b] < key[best])) best = b;
      if (best != a) begin
        t = key[a]; key[a] = key[best]; key[best] = t;
        t = raw[a]; raw[a] = raw[best]; raw[best] = t;
        sw++;
      end
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(12'(raw[k]));
      shadow[sel][k] = raw[k];
    end
  endtask

  task automatic readback(input string tag);
    logic [11:0] v;
    for (int k = 0; k < cfg_d[sel]; k++) begin
      read_mem(k, v);
      if (exp_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
      else check($sformatf("%s_e%0d", tag, k), v, exp_q.pop_front());
    end
  endtask

  task automatic run_sort(input string tag, input bit d, input bit noisy);
    int sw, n, cycles;
    n = cfg_d[sel];
    model_sort(d, sw);
    start_v = 1'b1;
    desc_v = d;
    tick();
    start_v = 1'b0;
    check({tag, "_busy"}, ready_m, 1'b0);
    cycles = 0;
    while (ready_m !== 1'b1 && cycles < 200) begin
      if (noisy && cycles == 5) begin
        wr_v = 1'b1; addr_v = 3'd0; din_v = 12'hFFF; start_v = 1'b1; desc_v = ~d;
      end
      if (noisy && cycles == 7) begin
        wr_v = 1'b0; start_v = 1'b0; desc_v = d;
      end
      tick();
      cycles++;
    end
    wr_v = 1'b0;
    start_v = 1'b0;
    check({tag, "_ready"}, ready_m, 1'b1);
    check({tag, "_cycles"}, cycles, (n - 1) + n * (n - 1) / 2 + sw);
    check({tag, "_swaps"}, swap_m, sw);
    readback(tag);
    check({tag, "_swaps_hold"}, swap_m, sw);
  endtask

  task automatic load(input int vals[8]);
    for (int k = 0; k < cfg_d[sel]; k++) write_mem(k, vals[k]);
  endtask

  initial begin
    logic [11:0] v, old;
    int vals[8];
    int sw;

    clear_shadow();
    tick();
    tick();
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("rst_ready%0d", s), ready_m, 1'b1);
      check($sformatf("rst_dout%0d", s), dout_m, 12'd0);
      check($sformatf("rst_swap%0d", s), swap_m, 3'd0);
      for (int k = 0; k < 8; k++) begin
        read_mem(k, v);
        check($sformatf("rst_mem%0d_%0d", s, k), v, 12'd0);
      end
    end

    sel = 0;
    vals = '{5, 3, 7, 1, 6, 2, 8, 4};
    load(vals);
    run_sort("asc", 1'b0, 1'b0);

    vals = '{1, 2, 3, 4, 5, 6, 7, 8};
    load(vals);
    run_sort("sorted", 1'b0, 1'b0);
    check("sorted_zero_swaps", swap_m, 3'd0);

    vals = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
    load(vals);
    run_sort("equal", 1'b1, 1'b0);

    // Read-old-on-write: a write at the same edge leaves dataout holding.
    read_mem(2, old);
    check("rw_read", old, 12'(shadow[0][2]));
    write_mem(2, 8'hA7);
    check("rw_hold", dout_m, old);
    read_mem(2, v);
    check("rw_new", v, 12'hA7);

    sel = 1;
    vals = '{8'hFF, 3, 8'h80, 8'h7F, 0, 0, 5, 8'hF9};
    load(vals);
    run_sort("sdesc", 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) vals[k] = $urandom_range(0, 255);
    load(vals);
    run_sort("noisy", 1'b0, 1'b1);

    sel = 2;
    vals = '{4095, 0, 2048, 1, 2048, 0, 0, 0};
    load(vals);
    write_mem(6, 12'hABC);
    read_mem(6, v);
    check("oob_read", v, 12'd0);
    run_sort("p5", 1'b0, 1'b0);

    for (int r = 0; r < 9; r++) begin
      sel = r % 3;
      for (int k = 0; k < 8; k++)
        vals[k] = (r < 3) ? $urandom_range(0, 3) : $urandom_range(0, (1 << cfg_w[sel]) - 1);
      load(vals);
      run_sort($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'b0);
    end

    sel = 0;
    for (int k = 0; k < 8; k++) vals[k] = $urandom_range(1, 255);
    load(vals);
    model_sort(1'b0, sw);
    exp_q.delete();
    start_v = 1'b1;
    desc_v = 1'b0;
    tick();
    start_v = 1'b0;
    repeat (10) tick();
    check("abort_busy", ready_m, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_shadow();
    check("abort_ready", ready_m, 1'b1);
    check("abort_swap", swap_m, 3'd0);
    for (int k = 0; k < 8; k++) begin
      read_mem(k, v);
      check($sformatf("abort_mem%0d", k), v, 12'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
